meas_pred_sched: RTL

Frame-level scheduler for the measurement-domain intra predictor. It accepts a per-frame configuration and walks the frame in raster block order. For each block it presents coordinates and the quantisation step to the predictor, and accepts one measurement vector per block through a valid/ready handshake. After the last block it drains the predictor pipeline and reports frame completion.

---
 rtl/meas_pred_pkg.sv | 16 +
 rtl/blk_raster_cnt.sv | 40 ++++
 rtl/meas_pred_sched.sv | 102 ++++++++++
 3 files changed

// File: rtl/meas_pred_pkg.sv
// Shared definitions for the measurement-domain intra predictor and its scheduler.
package meas_pred_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam int DEF_PIC_WID_IN_BLK_LEN = 11;
    localparam int DEF_PIC_HT_IN_BLK_LEN  = 10;
    localparam int DEF_QSTEP_WID          = 3;
    localparam int DEF_N_STAGES           = 4;

endpackage

// File: rtl/blk_raster_cnt.sv
// Raster-order block coordinate counter: X runs 0..last_x, then wraps and bumps Y.
module blk_raster_cnt #(
    parameter int X_LEN = 11,
    parameter int Y_LEN = 10
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             clr,
    input  logic             adv,
    input  logic [X_LEN-1:0] last_x,
    input  logic [Y_LEN-1:0] last_y,
    output logic [X_LEN-1:0] cor_x,
    output logic [Y_LEN-1:0] cor_y,
    output logic             last_blk
);

    // Coordinate register: clear has priority; advance wraps X at last_x.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cor_x <= '0;
            cor_y <= '0;
        end else if (clr) begin
            cor_x <= '0;
            cor_y <= '0;
        end else if (adv) begin
            if (cor_x == last_x) begin
                cor_x <= '0;
                cor_y <= cor_y + Y_LEN'(1);
            end else begin
                cor_x <= cor_x + X_LEN'(1);
            end
        end
    end

    // Final block of the frame flag.
    always_comb begin
        last_blk = (cor_x == last_x) && (cor_y == last_y);
    end

endmodule

// File: rtl/meas_pred_sched.sv
// Frame scheduler: latches frame config, walks blocks in raster order via a
// valid/ready handshake, drains the predictor pipeline, then pulses frame_done.
import meas_pred_pkg::*;

module meas_pred_sched #(
    parameter int PIC_WID_IN_BLK_LEN = DEF_PIC_WID_IN_BLK_LEN,
    parameter int PIC_HT_IN_BLK_LEN  = DEF_PIC_HT_IN_BLK_LEN,
    parameter int QSTEP_WID          = DEF_QSTEP_WID,
    parameter int N_STAGES           = DEF_N_STAGES
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic                          cfg_start,
    input  logic [PIC_WID_IN_BLK_LEN-1:0] cfg_last_x,
    input  logic [PIC_HT_IN_BLK_LEN-1:0]  cfg_last_y,
    input  logic [QSTEP_WID-1:0]          cfg_qstep,
    output logic                          busy,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          out_ready,
    output logic                          en_i,
    output logic [PIC_WID_IN_BLK_LEN-1:0] cor_X,
    output logic [PIC_HT_IN_BLK_LEN-1:0]  cor_Y,
    output logic [QSTEP_WID-1:0]          Qstep,
    output logic                          last_blk,
    output logic                          frame_done
);

    localparam int DRAIN_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    sched_state_t                  state_q, state_d;
    logic [PIC_WID_IN_BLK_LEN-1:0] last_x_q;
    logic [PIC_HT_IN_BLK_LEN-1:0]  last_y_q;
    logic [DRAIN_W-1:0]            drain_cnt;
    logic                          fire;
    logic                          start_ok;

    assign fire     = in_valid & in_ready;
    assign en_i     = fire;
    assign start_ok = (state_q == IDLE) & cfg_start;

    // State register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_start) state_d = RUN;
            RUN:     if (fire && last_blk) state_d = DRAIN;
            DRAIN:   if (drain_cnt == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs; in_ready passes downstream readiness through in RUN.
    always_comb begin
        busy       = (state_q != IDLE);
        in_ready   = (state_q == RUN) & out_ready;
        frame_done = (state_q == DONE);
    end

    // Frame config latch (IDLE only) and pipeline drain counter.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            last_x_q  <= '0;
            last_y_q  <= '0;
            Qstep     <= '0;
            drain_cnt <= '0;
        end else begin
            if (start_ok) begin
                last_x_q <= cfg_last_x;
                last_y_q <= cfg_last_y;
                Qstep    <= cfg_qstep;
            end
            if (state_q == RUN && fire && last_blk)
                drain_cnt <= DRAIN_W'(N_STAGES - 1);
            else if (state_q == DRAIN)
                drain_cnt <= drain_cnt - DRAIN_W'(1);
        end
    end

    blk_raster_cnt #(
        .X_LEN (PIC_WID_IN_BLK_LEN),
        .Y_LEN (PIC_HT_IN_BLK_LEN)
    ) u_raster (
        .clk      (clk),
        .arst     (arst),
        .clr      (start_ok),
        .adv      (fire & ~last_blk),
        .last_x   (last_x_q),
        .last_y   (last_y_q),
        .cor_x    (cor_X),
        .cor_y    (cor_Y),
        .last_blk (last_blk)
    );

endmodule
